// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port arbiter serialising m0/m1 requests onto the SDRAM controller host port
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin contention; default build gives m0 fixed priority.
module sdram_arbiter #(
   parameter int HADDR_WIDTH = 24,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m0_wr_req,
   input  logic                   m0_rd_req,
   input  logic [HADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0]  m0_wr_data,
   output logic                   m0_ack,
   output logic [DATA_WIDTH-1:0]  m0_rd_data,
   output logic                   m0_rd_valid,
   input  logic                   m1_wr_req,
   input  logic                   m1_rd_req,
   input  logic [HADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0]  m1_wr_data,
   output logic                   m1_ack,
   output logic [DATA_WIDTH-1:0]  m1_rd_data,
   output logic                   m1_rd_valid,
   output logic                   ctl_wr_enable,
   output logic                   ctl_rd_enable,
   output logic [HADDR_WIDTH-1:0] ctl_addr,
   output logic [DATA_WIDTH-1:0]  ctl_wr_data,
   input  logic                   ctl_busy,
   input  logic [DATA_WIDTH-1:0]  ctl_rd_data,
   input  logic                   ctl_rd_ready
);
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]             r_state;
   logic                   r_op_wr;
   logic                   r_owner;
   logic                   r_rd_seen;
   logic [3:0]             r_wait_cnt;
   logic [HADDR_WIDTH-1:0] r_ctl_addr;
   logic [DATA_WIDTH-1:0]  r_ctl_wr_data;
   logic [DATA_WIDTH-1:0]  r_m0_rd_data;
   logic [DATA_WIDTH-1:0]  r_m1_rd_data;
   logic                   r_m0_rd_valid;
   logic                   r_m1_rd_valid;

   logic w_m0_req;
   logic w_m1_req;
   logic w_grant;
   logic w_winner;
   logic w_win_wr;
   logic w_rd_ret;

   assign w_m0_req = m0_wr_req | m0_rd_req;
   assign w_m1_req = m1_wr_req | m1_rd_req;
   assign w_grant  = (r_state == S_IDLE) && (w_m0_req || w_m1_req) && !ctl_busy;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   // r_last_grant holds the owner of the previous grant; contention goes to the other port
   logic r_last_grant;

   assign w_winner = (w_m0_req && w_m1_req) ? ~r_last_grant : w_m1_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (w_grant) begin
         r_last_grant <= w_winner;
      end
   end
`else
   assign w_winner = ~w_m0_req & w_m1_req;
`endif

   // write beats read when one port raises both
   assign w_win_wr = w_winner ? m1_wr_req : m0_wr_req;
   assign w_rd_ret = (r_state == S_WAIT_DONE) && !r_op_wr && !r_rd_seen && ctl_rd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_op_wr       <= 1'b0;
         r_owner       <= 1'b0;
         r_rd_seen     <= 1'b0;
         r_wait_cnt    <= 4'd0;
         r_ctl_addr    <= '0;
         r_ctl_wr_data <= '0;
         r_m0_rd_data  <= '0;
         r_m1_rd_data  <= '0;
         r_m0_rd_valid <= 1'b0;
         r_m1_rd_valid <= 1'b0;
      end else begin
         r_m0_rd_valid <= 1'b0;
         r_m1_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_state       <= S_ISSUE;
                  r_owner       <= w_winner;
                  r_op_wr       <= w_win_wr;
                  r_ctl_addr    <= w_winner ? m1_addr : m0_addr;
                  r_ctl_wr_data <= w_winner ? m1_wr_data : m0_wr_data;
               end
            end
            S_ISSUE: begin
               r_state    <= S_WAIT_BUSY;
               r_wait_cnt <= 4'd0;
               r_rd_seen  <= 1'b0;
            end
            S_WAIT_BUSY: begin
               // give up after 15 cycles without busy and treat the command as complete
               if (ctl_busy) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_wait_cnt == 4'd14) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            S_WAIT_DONE: begin
               if (r_op_wr) begin
                  if (!ctl_busy) begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  if (w_rd_ret) begin
                     r_rd_seen <= 1'b1;
                     if (r_owner) begin
                        r_m1_rd_data  <= ctl_rd_data;
                        r_m1_rd_valid <= 1'b1;
                     end else begin
                        r_m0_rd_data  <= ctl_rd_data;
                        r_m0_rd_valid <= 1'b1;
                     end
                  end
                  if ((r_rd_seen || ctl_rd_ready) && !ctl_busy) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ctl_wr_enable = (r_state == S_ISSUE) &&  r_op_wr;
   assign ctl_rd_enable = (r_state == S_ISSUE) && !r_op_wr;
   assign m0_ack        = (r_state == S_ISSUE) && !r_owner;
   assign m1_ack        = (r_state == S_ISSUE) &&  r_owner;
   assign ctl_addr      = r_ctl_addr;
   assign ctl_wr_data   = r_ctl_wr_data;
   assign m0_rd_data    = r_m0_rd_data;
   assign m1_rd_data    = r_m1_rd_data;
   assign m0_rd_valid   = r_m0_rd_valid;
   assign m1_rd_valid   = r_m1_rd_valid;
endmodule
